// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button request controller: synchronizer, debounce, request/ack FSM, holdoff.
// Optional accepted-request counter enabled by defining macro PED_REQ_COUNT_EN.
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 300000,
  parameter int HOLDOFF_TICKS   = 20
) (
  input  logic       clk30M,
  input  logic       Reset,
  input  logic       tick1,
  input  logic       btn_n,
  input  logic       ack,
  output logic       req,
  output logic       req_pulse,
  output logic       btn_clean,
  output logic       holdoff_busy,
  output logic [7:0] req_count
);

  localparam logic [19:0] DB_MAX  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HO_LOAD = 8'(HOLDOFF_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_btn_clean;
  logic        r_btn_clean_d;
  logic [19:0] r_db_cnt;
  logic [7:0]  r_hold_cnt;
  logic        r_req_pulse;
  logic        w_sync_pressed;
  logic        w_press;
  logic        w_accept;
  logic        w_hold_load;
  logic        w_hold_dec;

  // Synchronizer idles at 1 (button released) so reset never looks like a press.
  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_pressed = ~r_sync2;

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_db_cnt      <= 20'd0;
      r_btn_clean   <= 1'b0;
      r_btn_clean_d <= 1'b0;
    end else begin
      r_btn_clean_d <= r_btn_clean;
      if (w_sync_pressed != r_btn_clean) begin
        if (r_db_cnt == DB_MAX) begin
          r_btn_clean <= w_sync_pressed;
          r_db_cnt    <= 20'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 20'd1;
        end
      end else begin
        r_db_cnt <= 20'd0;
      end
    end
  end

  // Only the rising edge of the debounced level is an event; release is silent.
  assign w_press = r_btn_clean & ~r_btn_clean_d;

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake: req rises with req_pulse and stays high until ack is sampled high
  // in PENDING; ack outside PENDING is ignored, and req drops the cycle after ack.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hold_load = 1'b0;
    w_hold_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt = ST_PENDING;
          w_accept    = 1'b1;
        end
      end
      ST_PENDING: begin
        if (ack) begin
          w_state_nxt = ST_HOLDOFF;
          w_hold_load = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else if (tick1) begin
          w_hold_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A tick coinciding with the entering ack is not counted: the load wins.
  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_hold_cnt <= 8'd0;
    end else if (w_hold_load) begin
      r_hold_cnt <= HO_LOAD;
    end else if (w_hold_dec) begin
      r_hold_cnt <= r_hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_req_pulse <= 1'b0;
    end else begin
      r_req_pulse <= w_accept;
    end
  end

`ifdef PED_REQ_COUNT_EN
  logic [7:0] r_req_count;

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_req_count <= 8'd0;
    end else if (w_accept && (r_req_count != 8'hFF)) begin
      r_req_count <= r_req_count + 8'd1;
    end
  end

  assign req_count = r_req_count;
`else
  assign req_count = 8'd0;
`endif

  assign req          = (r_state == ST_PENDING);
  assign holdoff_busy = (r_state == ST_HOLDOFF);
  assign req_pulse    = r_req_pulse;
  assign btn_clean    = r_btn_clean;

endmodule
